ex_muldiv_ctrl: RTL and testbench
=================================

// Module: ex_muldiv_ctrl
// PURPOSE
//  EX-stage sequencer for multi-cycle multiply/divide, owning the HI/LO architectural registers.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX control word.
//  Runs an iterative shift-add multiplier or a restoring divider, one iteration per cycle.
//  Drives stall_E to the hazard unit while an op is in flight, or while MFHI/MFLO would read stale HI/LO.
// PARAMETERS
//  WIDTH   32   operand width; equals `N+1; iteration count = WIDTH
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      EX holds a mul/div/mt op this cycle
//  op         in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
//  src_a      in   WIDTH  rs operand (dividend / multiplicand / MT data)
//  src_b      in   WIDTH  rt operand (divisor / multiplier)
//  mf_req     in   1      EX holds MFHI or MFLO this cycle
//  flush      in   1      kill EX-stage op and any op in flight
//  busy       out  1      iteration in progress
//  done       out  1      one-cycle pulse: new HI/LO from mul/div is visible this cycle
//  stall_E    out  1      hold IF/ID/EX this cycle
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; hi=0, lo=0, busy=0, done=0; iteration counter=0. Reset aborts any op in flight.
//  States:
//   IDLE -> RUN    start & mul/div op & !flush
//   RUN  -> IDLE   after WIDTH iterations, or on flush
//  Accept: start with a mul/div op in cycle T while busy=0 is taken at the end of T.
//   - busy=1 for cycles T+1..T+WIDTH.
//   - hi/lo written at the edge ending T+WIDTH.
//   - In T+WIDTH+1: hi/lo hold the result, done=1, busy=0.
//   - Result latency: WIDTH+1 cycles from the start cycle.
//  Operand latching: src_a/src_b are latched at accept. They may change during RUN.
//  MTHI/MTLO: accepted only when busy=0; hi (resp. lo) <= src_a at the end of T. No busy, no done.
//  NOP op codes with start=1: ignored, no stall.
//  stall_E = busy & (start | mf_req). This is combinational.
//   - start asserted while busy: op is not accepted and the instruction is held.
//   - The op is accepted in the first cycle busy=0.
//   - A back-to-back op therefore starts in the done cycle.
//  mf_req while busy=0: no stall; hi/lo are the current register values.
//   - In the done cycle MFHI/MFLO read the new result.
//  MULTU: {hi,lo} = src_a * src_b, 2*WIDTH-bit unsigned product.
//  MULT: signed operands.
//   - Magnitudes are multiplied.
//   - The 2*WIDTH-bit product is negated in the final write if the operand signs differ.
//  DIVU: lo = quotient, hi = remainder.
//  DIV: quotient truncated toward zero; remainder takes the sign of the dividend.
//   - Sign fix-up is applied combinationally in the final write; it adds no cycle.
//  Divide by zero (DIV or DIVU): lo = all ones, hi = src_a as latched.
//   - Full WIDTH-cycle latency still applies.
//  DIV overflow (min_int / -1): lo = min_int, hi = 0.
//  flush:
//   - Flush in IDLE: start is ignored; MT ops are not written.
//   - Flush in RUN: state returns to IDLE next cycle, busy=0, no done, hi/lo unchanged.
//   - flush & start in the same cycle: flush wins.
//   - stall_E is forced to 0 in any cycle with flush=1.
//  Simultaneous reset & flush: reset dominates; same end state.
//  Counter: counts 0..WIDTH-1 and does not wrap past WIDTH-1.
//   - The counter clears on accept, flush and reset.
// TESTING
//  1. MULTU a=FFFFFFFF b=FFFFFFFF -> busy for 32 cycles; cycle T+33: done=1, hi=FFFFFFFE, lo=00000001
//  2. MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1
//  3. DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF
//     DIV 80000000/FFFFFFFF -> lo=80000000 hi=0
//  4. DIVU a=00000009 b=0 -> lo=FFFFFFFF hi=00000009 after 33 cycles
//  5. MULTU started, flush at T+10 -> busy=0 at T+11, done never pulses, hi/lo keep prior values
//  6. DIVU in flight, then mf_req=1 and start(MTHI, src_a=12345678)
//     -> stall_E=1 until done cycle; MFHI in done cycle sees quotient-run hi; MTHI is accepted
//        in the done cycle, so hi=12345678 in the next cycle; reset mid-RUN -> all outputs 0 next cycle

Source files
------------

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage mul/div handshake bundle: control word in, HI/LO and stall out.
interface ex_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mf_req;
    logic             flush;
    logic             busy;
    logic             done;
    logic             stall_E;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, mf_req, flush,
        input  busy, done, stall_E, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, mf_req, flush,
        output busy, done, stall_E, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative mul/div sequencer owning HI/LO.
// Shift-add multiply and restoring divide share one accumulator pair.
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    ex_muldiv_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, mcand, a_raw;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             op_div, neg_q, neg_r, b_zero, done_q;

    logic             idle, accept, mt_hi, mt_lo, last;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign idle   = (state == IDLE);
    assign accept = idle & bus.start & ~bus.op[2] & ~bus.flush;
    assign mt_hi  = idle & bus.start & ~bus.flush & (bus.op == 3'b100);
    assign mt_lo  = idle & bus.start & ~bus.flush & (bus.op == 3'b101);
    assign last   = (state == RUN) & ~bus.flush & (cnt == CW'(WIDTH - 1));

    // Even op codes (MULT, DIV) are the signed variants.
    assign sgn   = ~bus.op[0];
    assign a_neg = sgn & bus.src_a[WIDTH-1];
    assign b_neg = sgn & bus.src_b[WIDTH-1];
    assign mag_a = a_neg ? -bus.src_a : bus.src_a;
    assign mag_b = b_neg ? -bus.src_b : bus.src_b;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = RUN;
            RUN:  if (bus.flush || last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod, prod_f;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, mcand};
        div_ok   = ~div_diff[WIDTH];
        div_hi_n = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_lo_n = {acc_lo[WIDTH-2:0], div_ok};

        prod   = {mul_hi_n, mul_lo_n};
        prod_f = neg_q ? -prod : prod;

        // Sign fix-up folded into the final write.
        if (!op_div) begin
            res_hi = prod_f[2*WIDTH-1:WIDTH];
            res_lo = prod_f[WIDTH-1:0];
        end else if (b_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = neg_r ? -div_hi_n : div_hi_n;
            res_lo = neg_q ? -div_lo_n : div_lo_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            a_raw  <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                cnt    <= '0;
                acc_hi <= '0;
                acc_lo <= bus.op[1] ? mag_a : mag_b;
                mcand  <= bus.op[1] ? mag_b : mag_a;
                a_raw  <= bus.src_a;
                op_div <= bus.op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= bus.op[1] & a_neg;
                b_zero <= bus.op[1] & (bus.src_b == '0);
            end else if (state == RUN) begin
                if (bus.flush) begin
                    cnt <= '0;
                end else begin
                    acc_hi <= op_div ? div_hi_n : mul_hi_n;
                    acc_lo <= op_div ? div_lo_n : mul_lo_n;
                    if (cnt != CW'(WIDTH - 1)) cnt <= cnt + 1'b1;
                end
            end
            if (last) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (mt_hi) begin
                hi_q <= bus.src_a;
            end else if (mt_lo) begin
                lo_q <= bus.src_a;
            end
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = done_q;
    assign bus.stall_E = bus.busy & (bus.start | bus.mf_req) & ~bus.flush;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl.
// Each task drives one scenario and checks it inline.
module tb_ex_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ex_muldiv_ctrl_if #(.WIDTH(32)) bus ();

    ex_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.op     = 3'b111;
        bus.src_a  = '0;
        bus.src_b  = '0;
        bus.mf_req = 1'b0;
        bus.flush  = 1'b0;
    endtask

    // Issues an op in the current cycle and ends in its done cycle.
    task automatic run_muldiv(input string name, input logic [2:0] o,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] eh, input logic [31:0] el);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        bus.op    = 3'b111;
        bus.src_a = 32'h5a5a_5a5a;
        bus.src_b = 32'ha5a5_a5a5;
        for (int i = 1; i <= 32; i++) begin
            #1;
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy/done T+%0d: got %b/%b need 1/0",
                         name, i, bus.busy, bus.done);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle: got done=%b busy=%b need 1/0",
                     name, bus.done, bus.busy);
        end
        checks++;
        if (bus.hi !== eh || bus.lo !== el) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h need hi=%h lo=%h",
                     name, bus.hi, bus.lo, eh, el);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.stall_E} !== 3'b000 ||
            bus.hi !== '0 || bus.lo !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h need zeros",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mul();
        run_muldiv("multu", 3'b001, 32'hffff_ffff, 32'hffff_ffff,
                   32'hffff_fffe, 32'h0000_0001);
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b need 0", bus.done);
        end
        run_muldiv("mult", 3'b000, 32'hffff_fffd, 32'h0000_0005,
                   32'hffff_ffff, 32'hffff_fff1);
        tick();
        run_muldiv("mult_negneg", 3'b000, 32'hffff_fff9, 32'hffff_fffa,
                   32'h0000_0000, 32'h0000_002a);
        tick();
    endtask

    task automatic test_div();
        run_muldiv("div", 3'b010, 32'hffff_fff9, 32'h0000_0002,
                   32'hffff_ffff, 32'hffff_fffd);
        tick();
        run_muldiv("div_ovf", 3'b010, 32'h8000_0000, 32'hffff_ffff,
                   32'h0000_0000, 32'h8000_0000);
        tick();
        run_muldiv("divu", 3'b011, 32'h0000_0064, 32'h0000_0007,
                   32'h0000_0002, 32'h0000_000e);
        tick();
        run_muldiv("div_by0", 3'b010, 32'hffff_fff0, 32'h0000_0000,
                   32'hffff_fff0, 32'hffff_ffff);
        tick();
        run_muldiv("divu_by0", 3'b011, 32'h0000_0009, 32'h0000_0000,
                   32'h0000_0009, 32'hffff_ffff);
        tick();
    endtask

    task automatic test_mt_nop();
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.src_a = 32'hcafe_babe;
        tick();
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.lo !== 32'hcafe_babe || bus.hi !== 32'h0000_0009 ||
            bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b need 00000009/cafebabe/0",
                     bus.hi, bus.lo, bus.busy);
        end
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.src_a = 32'h1111_1111;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.op    = 3'b110;
        bus.mf_req = 1'b1;
        #1;
        checks++;
        if (bus.hi !== 32'h0000_0009) begin
            errors++;
            $display("FAIL mthi_flush: got hi=%h need 00000009", bus.hi);
        end
        checks++;
        if (bus.stall_E !== 1'b0) begin
            errors++;
            $display("FAIL nop_stall: got %b need 0", bus.stall_E);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0000_0009 ||
            bus.lo !== 32'hcafe_babe) begin
            errors++;
            $display("FAIL nop_ignored: got busy=%b hi=%h lo=%h",
                     bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush();
        bit seen_done = 1'b0;
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.src_a = 32'h0000_0005;
        bus.src_b = 32'h0000_0005;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        bus.flush  = 1'b1;
        bus.mf_req = 1'b1;
        bus.start  = 1'b1;
        #1;
        checks++;
        if (bus.stall_E !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall: got stall=%b busy=%b need 0/1",
                     bus.stall_E, bus.busy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got %b need 0", bus.busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_done || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_nodone: got done_seen=%b busy=%b need 0/0",
                     seen_done, bus.busy);
        end
        checks++;
        if (bus.hi !== 32'h0000_0009 || bus.lo !== 32'hcafe_babe) begin
            errors++;
            $display("FAIL flush_hold: got hi=%h lo=%h need 00000009/cafebabe",
                     bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        run_muldiv("b2b_mul", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);
        run_muldiv("b2b_div", 3'b011, 32'd42, 32'd5, 32'd2, 32'd8);
        tick();
    endtask

    task automatic test_mf_stall();
        int stall_bad = 0;
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        tick();
        bus.op     = 3'b100;
        bus.src_a  = 32'h1234_5678;
        bus.mf_req = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            #1;
            if (bus.stall_E !== 1'b1) stall_bad++;
            tick();
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL mf_stall: got %0d unstalled cycles need 0", stall_bad);
        end
        #1;
        checks++;
        if (bus.stall_E !== 1'b0 || bus.done !== 1'b1 ||
            bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            errors++;
            $display("FAIL mf_done: got stall=%b done=%b hi=%h lo=%h need 0/1/2/e",
                     bus.stall_E, bus.done, bus.hi, bus.lo);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'd14 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi_after_done: got hi=%h lo=%h busy=%b",
                     bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_reset_midrun();
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mf_req = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.stall_E} !== 3'b000 ||
            bus.hi !== '0 || bus.lo !== '0) begin
            errors++;
            $display("FAIL reset_midrun: got busy=%b done=%b stall=%b hi=%h lo=%h",
                     bus.busy, bus.done, bus.stall_E, bus.hi, bus.lo);
        end
        bus.mf_req = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (bus.lo !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got lo=%h busy=%b need 0/0",
                     bus.lo, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mt_nop();
        test_flush();
        test_back_to_back();
        test_mf_stall();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
